// File: rtl/cp_outbuf_rd_stream_if.sv
// Bundle of the streamer's control, OutBuf read-port and output-stream signals.
//   master : the streamer (drives status, read strobe/address, stream word)
//   slave  : the environment (drives start request, read data, sink ready)
interface cp_outbuf_rd_stream_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              iStart;
  logic [ADDR_W-1:0] iStartAddr;
  logic [ADDR_W:0]   iWordCnt;
  logic              oBusy;
  logic              oDone;
  logic              oRdEn_OutBuf;
  logic [ADDR_W-1:0] oRdAddr_OutBuf;
  logic [DATA_W-1:0] iRdDt_OutBuf;
  logic              oTxValid;
  logic              iTxReady;
  logic [DATA_W-1:0] oTxData;
  logic              oTxLast;

  modport master (
    input  iStart, iStartAddr, iWordCnt, iRdDt_OutBuf, iTxReady,
    output oBusy, oDone, oRdEn_OutBuf, oRdAddr_OutBuf, oTxValid, oTxData, oTxLast
  );

  modport slave (
    output iStart, iStartAddr, iWordCnt, iRdDt_OutBuf, iTxReady,
    input  oBusy, oDone, oRdEn_OutBuf, oRdAddr_OutBuf, oTxValid, oTxData, oTxLast
  );
endinterface

// File: rtl/cp_outbuf_rd_stream.sv
// OutBuf read streamer: on a start request issues sequential word reads on the
// OutBuf read port and forwards the returned words as a valid/ready stream
// with last-word marking. A credit-limited FIFO absorbs the one-cycle read
// latency and sink backpressure.
// Ports:
//   iClk, iRst : clock, synchronous active-high reset
//   bus        : master side of cp_outbuf_rd_stream_if (start/status,
//                OutBuf read port, output stream)
module cp_outbuf_rd_stream #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                      iClk,
  input  logic                      iRst,
  cp_outbuf_rd_stream_if.master     bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned WC_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [WC_W-1:0]   issue_rem;
  logic [WC_W-1:0]   tx_rem, tx_rem_nxt;
  logic              pend;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nxt;
  logic              tx_valid, tx_last, busy, done;
  logic              rd_en_c, start_c, pop_c, fin_c, credit_c;

  // Next-state, read strobe and counter updates
  always_comb begin
    state_nxt    = state;
    rd_en_c      = 1'b0;
    start_c      = 1'b0;
    pop_c        = tx_valid && bus.iTxReady;
    fin_c        = pop_c && (tx_rem == WC_W'(1));
    // Words already buffered plus the one in flight must leave room for another
    credit_c     = (SUM_W'(fifo_cnt) + SUM_W'(pend)) < SUM_W'(FIFO_DEPTH);
    fifo_cnt_nxt = fifo_cnt;
    tx_rem_nxt   = tx_rem;

    case (state)
      IDLE: begin
        if (bus.iStart) begin
          start_c   = 1'b1;
          state_nxt = (bus.iWordCnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en_c = (issue_rem != '0) && credit_c;
        if (fin_c)                  state_nxt = DONE;
        else if (issue_rem == '0)   state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fin_c) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    case ({pend, pop_c})
      2'b10:   fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
      2'b01:   fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
      default: fifo_cnt_nxt = fifo_cnt;
    endcase

    if (start_c)    tx_rem_nxt = bus.iWordCnt;
    else if (pop_c) tx_rem_nxt = tx_rem - WC_W'(1);
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Address/count tracking, FIFO storage and registered stream/status outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      addr      <= '0;
      issue_rem <= '0;
      tx_rem    <= '0;
      pend      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (start_c) begin
        addr      <= bus.iStartAddr;
        issue_rem <= bus.iWordCnt;
      end else if (rd_en_c) begin
        addr      <= addr + ADDR_W'(1);
        issue_rem <= issue_rem - WC_W'(1);
      end
      // pend marks that read data arrives on the port this cycle
      pend <= rd_en_c;
      if (pend) begin
        mem[wr_ptr] <= bus.iRdDt_OutBuf;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt_nxt;
      tx_rem   <= tx_rem_nxt;
      tx_valid <= (fifo_cnt_nxt != '0);
      tx_last  <= (fifo_cnt_nxt != '0) && (tx_rem_nxt == WC_W'(1));
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
    end
  end

  assign bus.oBusy          = busy;
  assign bus.oDone          = done;
  assign bus.oRdEn_OutBuf   = rd_en_c;
  assign bus.oRdAddr_OutBuf = addr;
  assign bus.oTxValid       = tx_valid;
  assign bus.oTxData        = mem[rd_ptr];
  assign bus.oTxLast        = tx_last;

endmodule
